circle_seq: RTL and testbench

CIRCLE_SEQ -- requirements
Module: circle_seq

---
 rtl/circle_pkg.sv | 21 ++
 rtl/circle_job_fifo.sv | 70 +++++++
 rtl/circle_seq.sv | 111 +++++++++++
 tb/tb_circle_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// Shared types for the circle job sequencer: the job record, FSM states and
// the default queue depth.
package circle_pkg;

    localparam int CIRCLE_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [7:0] centre_x;
        logic [6:0] centre_y;
        logic [7:0] radius;
        logic [2:0] colour;
    } circle_job_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } circle_state_t;

endpackage

// File: rtl/circle_job_fifo.sv
// Circular job queue with wrapping pointers and an occupancy count; flush
// empties it in one edge and wins over a coincident push.
module circle_job_fifo
    import circle_pkg::*;
#(
    parameter int  DEPTH = CIRCLE_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  circle_job_t wr_job,
    output circle_job_t rd_job,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    circle_job_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_job  = mem_q[rd_ptr_q];
    // A full queue refuses a push even when the same edge pops.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_job;
    end

endmodule

// File: rtl/circle_seq.sv
// Queues circle drawing jobs and hands them one at a time to the circle
// engine with a start/done level handshake; counts completed jobs.
module circle_seq
    import circle_pkg::*;
#(
    parameter int DEPTH = CIRCLE_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_centre_x,
    input  logic [6:0] req_centre_y,
    input  logic [7:0] req_radius,
    input  logic [2:0] req_colour,
    input  logic       flush,
    output logic       eng_start,
    output logic [7:0] eng_centre_x,
    output logic [6:0] eng_centre_y,
    output logic [7:0] eng_radius,
    output logic [2:0] eng_colour,
    input  logic       eng_done,
    output logic       busy,
    output logic [7:0] jobs_done
);

    localparam int AW = $clog2(DEPTH);

    circle_state_t state_q, state_d;
    circle_job_t   job_q, job_d;
    circle_job_t   req_job, head_job;
    logic          eng_start_q, eng_start_d;
    logic [7:0]    jobs_done_q, jobs_done_d;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [AW:0]   fifo_count;

    assign req_job = {req_centre_x, req_centre_y, req_radius, req_colour};

    circle_job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (req_valid),
        .pop    (fifo_pop),
        .flush  (flush),
        .wr_job (req_job),
        .rd_job (head_job),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        job_d       = job_q;
        eng_start_d = eng_start_q;
        jobs_done_d = jobs_done_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                eng_start_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    job_d    = head_job;
                    state_d  = LOAD;
                end
            end
            LOAD: state_d = RUN;
            // Start rises one edge into RUN and is held until done is seen.
            RUN: begin
                if (eng_done) begin
                    eng_start_d = 1'b0;
                    state_d     = RELEASE;
                end else begin
                    eng_start_d = 1'b1;
                end
            end
            RELEASE: begin
                eng_start_d = 1'b0;
                if (!eng_done) begin
                    jobs_done_d = jobs_done_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            job_q       <= '0;
            eng_start_q <= 1'b0;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            eng_start_q <= eng_start_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign req_ready    = !fifo_full;
    assign busy         = (state_q != IDLE) || (fifo_count != '0);
    assign eng_start    = eng_start_q;
    assign eng_centre_x = job_q.centre_x;
    assign eng_centre_y = job_q.centre_y;
    assign eng_radius   = job_q.radius;
    assign eng_colour   = job_q.colour;
    assign jobs_done    = jobs_done_q;

endmodule

// File: tb/tb_circle_seq.sv
// Bench for circle_seq: directed scenarios plus randomized jobs against an
// in-order job queue model and a behavioural engine.
module tb_circle_seq;

    logic       clk;
    logic       rst_n;
    logic       req_valid, req_ready, flush;
    logic [7:0] req_centre_x, req_radius;
    logic [6:0] req_centre_y;
    logic [2:0] req_colour;
    logic       eng_start, eng_done, busy;
    logic [7:0] eng_centre_x, eng_radius, jobs_done;
    logic [6:0] eng_centre_y;
    logic [2:0] eng_colour;

    int          checks = 0;
    int          errors = 0;
    logic [25:0] exp_q[$];
    int          completions = 0;
    int          done_delay = 5;
    int          done_hold = 0;
    bit          stall = 1'b0;
    logic        prev_start = 1'b0;

    circle_seq #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_centre_x (req_centre_x),
        .req_centre_y (req_centre_y),
        .req_radius   (req_radius),
        .req_colour   (req_colour),
        .flush        (flush),
        .eng_start    (eng_start),
        .eng_centre_x (eng_centre_x),
        .eng_centre_y (eng_centre_y),
        .eng_radius   (eng_radius),
        .eng_colour   (eng_colour),
        .eng_done     (eng_done),
        .busy         (busy),
        .jobs_done    (jobs_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] rand_job();
        return {8'($urandom), 7'($urandom), 8'($urandom), 3'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a job for one edge; the model queue records it only if it was taken.
    task automatic push_job(input logic [25:0] j);
        logic acc;
        {req_centre_x, req_centre_y, req_radius, req_colour} = j;
        req_valid = 1'b1;
        acc = req_ready && !flush;
        tick();
        req_valid = 1'b0;
        if (acc) exp_q.push_back(j);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || eng_start || eng_done) && n < limit) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(n < limit), 1);
    endtask

    task automatic wait_start(input int limit);
        int n = 0;
        while (!eng_start && n < limit) begin
            tick();
            n++;
        end
        check("start_seen", eng_start, 1);
    endtask

    // Engine: done after done_delay cycles (or when unstalled), lowered
    // done_hold cycles after start falls.
    initial begin
        eng_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (eng_start === 1'b1 && !eng_done) begin : eng_job
                int cnt;
                cnt = 0;
                while (eng_start && (stall || cnt < done_delay)) begin
                    @(posedge clk);
                    #2;
                    cnt++;
                end
                if (eng_start) begin
                    eng_done = 1'b1;
                    cnt = 0;
                    while (eng_start && cnt < 1000) begin
                        @(posedge clk);
                        #2;
                        cnt++;
                    end
                    repeat (done_hold) begin
                        @(posedge clk);
                        #2;
                    end
                    eng_done = 1'b0;
                    completions++;
                end
            end
        end
    end

    // Every new start must carry the oldest accepted job and never overlap done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && eng_start && !prev_start) begin
                check("start_while_done_high", eng_done, 0);
                check("start_has_queued_job", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0)
                    check("job_order", {eng_centre_x, eng_centre_y, eng_radius, eng_colour},
                          exp_q.pop_front());
            end
            prev_start = eng_start;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0;
        flush = 1'b0;
        {req_centre_x, req_centre_y, req_radius, req_colour} = '0;
        repeat (3) tick();
        check("reset_eng_start", eng_start, 0);
        check("reset_jobs_done", jobs_done, 0);
        check("reset_fields", {eng_centre_x, eng_centre_y, eng_radius, eng_colour}, 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_ready", req_ready, 1);
        check("post_reset_busy", busy, 0);

        // Single job, engine done 50 cycles after start
        done_delay = 50;
        push_job({8'd80, 7'd60, 8'd20, 3'd3});
        tick();
        tick();
        check("start_latency_early", eng_start, 0);
        tick();
        check("start_latency", eng_start, 1);
        n = 0;
        while (eng_start && n < 200) begin
            tick();
            n++;
        end
        check("start_fell", eng_start, 0);
        check("start_fell_after_done", eng_done, 1);
        wait_idle(100);
        check("jobs_done_single", jobs_done, 1);

        // Back-to-back pushes into a stalled engine
        stall = 1'b1;
        done_delay = 3;
        for (int i = 0; i < 5; i++) begin
            check("ready_before_push", req_ready, 1);
            push_job(rand_job());
        end
        check("ready_when_full", req_ready, 0);
        push_job(rand_job());
        check("ready_still_full", req_ready, 0);
        check("busy_when_full", busy, 1);
        stall = 1'b0;
        wait_idle(1000);
        check("jobs_done_burst", jobs_done, 6);

        // Engine holding done high after start falls
        done_delay = 4;
        done_hold = 10;
        for (int i = 0; i < 3; i++) push_job(rand_job());
        wait_idle(1000);
        check("jobs_done_stale", jobs_done, 9);
        done_hold = 0;

        // Flush three queued jobs while one runs; a coincident push is dropped
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push_job(rand_job());
        wait_start(20);
        flush = 1'b1;
        push_job(rand_job());
        flush = 1'b0;
        exp_q.delete();
        check("ready_after_flush", req_ready, 1);
        check("busy_during_run", busy, 1);
        check("start_kept_after_flush", eng_start, 1);
        stall = 1'b0;
        wait_idle(200);
        check("jobs_done_flush", jobs_done, 10);
        check("busy_after_flush", busy, 0);
        repeat (10) tick();
        check("no_start_after_flush", eng_start, 0);

        // Reset during RUN with queued jobs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) push_job(rand_job());
        wait_start(20);
        rst_n = 1'b0;
        tick();
        check("reset_run_start", eng_start, 0);
        check("reset_run_jobs_done", jobs_done, 0);
        check("reset_run_ready", req_ready, 1);
        check("reset_run_busy", busy, 0);
        rst_n = 1'b1;
        exp_q.delete();
        completions = 0;
        stall = 1'b0;
        repeat (10) tick();
        check("no_start_after_reset", eng_start, 0);
        done_delay = 2;
        push_job(rand_job());
        wait_idle(100);
        check("jobs_done_after_reset", jobs_done, 1);

        // Randomized traffic with occasional flushes during RUN
        for (int i = 0; i < 60; i++) begin
            done_delay = int'($urandom_range(0, 6));
            done_hold = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) push_job(rand_job());
            else tick();
            if (eng_start && $urandom_range(0, 7) == 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                exp_q.delete();
            end
        end
        wait_idle(2000);
        check("jobs_done_random", jobs_done, 32'(completions % 256));

        // Counter wrap at 256 completions
        done_delay = 0;
        done_hold = 0;
        while (completions < 255) begin
            push_job(rand_job());
            wait_idle(100);
        end
        check("jobs_done_255", jobs_done, 255);
        push_job(rand_job());
        wait_idle(100);
        check("jobs_done_wrap", jobs_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
